// File: rtl/eth_tx_frame_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : eth_tx_frame_fifo
//  Description : Store-and-forward Ethernet TX frame buffer. Frames are
//                committed only on a clean tlast, then streamed to the MAC
//                with tvalid held from first beat to tlast. Aborted and
//                oversize frames are discarded and counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_frame_fifo #(
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              resetn,

    input  logic [63:0]       s_axis_tdata,
    input  logic [7:0]        s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,

    output logic [63:0]       m_axis_tdata,
    output logic [7:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,

    output logic [ADDR_W:0]   frames_pending,
    output logic [15:0]       drop_count
);

    localparam int              c_DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_PTR_MSB  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [15:0]     c_DROP_MAX = 16'hFFFF;

    localparam logic [0:0]      c_ST_WRITE = 1'b0;
    localparam logic [0:0]      c_ST_DROP  = 1'b1;

    // ------------------------------------------------------------------
    // Storage: {tlast, tkeep, tdata}
    // ------------------------------------------------------------------
    logic [72:0]       r_mem [0:c_DEPTH-1];
    logic [72:0]       r_ram_q;

    // ------------------------------------------------------------------
    // Write side state
    // ------------------------------------------------------------------
    logic [0:0]        r_state;
    logic              r_in_en;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_wr_start;
    logic [ADDR_W:0]   r_wr_commit;
    logic [15:0]       r_drop_count;
    logic [ADDR_W:0]   r_frames_pending;

    // ------------------------------------------------------------------
    // Read side state
    // ------------------------------------------------------------------
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_rd_pend;
    logic [1:0]        r_ob_cnt;
    logic [72:0]       r_head;
    logic [72:0]       r_skid;
    logic              r_out_valid;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic              w_full;
    logic [ADDR_W:0]   w_frame_len;
    logic              w_overflow;
    logic              w_s_ready;
    logic              w_s_hs;
    logic              w_wr_en;
    logic              w_commit;
    logic              w_abort;
    logic              w_drop_evt;
    logic [ADDR_W:0]   w_wr_ptr_inc;
    logic [ADDR_W:0]   w_commit_ptr;
    logic [72:0]       w_wr_word;

    logic              w_out_pop;
    logic              w_out_last_hs;
    logic              w_push;
    logic              w_room;
    logic              w_rd_en;
    logic [1:0]        w_ob_cnt_nxt;
    logic              w_load_head_q;
    logic              w_load_head_skid;
    logic              w_load_skid;

    // Full when the pointers differ only in the wrap bit.
    assign w_full       = (r_wr_ptr ^ r_rd_ptr) == c_PTR_MSB;
    assign w_frame_len  = r_wr_ptr - r_wr_start;

    // The in-progress frame alone fills the buffer: it can never be committed.
    assign w_overflow   = (r_state == c_ST_WRITE) && w_full && (w_frame_len == c_PTR_MSB);

    // Overflow keeps tready high so the sender is never stalled by a frame
    // that is going to be discarded anyway.
    assign w_s_ready    = r_in_en &&
                          ((r_state == c_ST_DROP) || w_overflow || !w_full);
    assign w_s_hs       = s_axis_tvalid && w_s_ready;
    assign w_wr_en      = w_s_hs && (r_state == c_ST_WRITE) && !w_overflow;
    assign w_commit     = w_wr_en && s_axis_tlast && !s_axis_tuser;
    assign w_abort      = w_wr_en && s_axis_tlast && s_axis_tuser;
    assign w_drop_evt   = w_abort || w_overflow;
    assign w_wr_ptr_inc = r_wr_ptr + c_PTR_ONE;
    assign w_wr_word    = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    // Reads may use the commit taking effect this cycle; the RAM forwards the
    // beat being written so a single-beat frame still meets the latency.
    assign w_commit_ptr = w_commit ? w_wr_ptr_inc : r_wr_commit;

    assign s_axis_tready = w_s_ready;

    // ------------------------------------------------------------------
    // Output staging: head register drives m_axis, skid catches the beat
    // already in flight from the RAM when the MAC stalls.
    // ------------------------------------------------------------------
    assign w_out_pop     = r_out_valid && m_axis_tready;
    assign w_out_last_hs = w_out_pop && r_head[72];
    assign w_push        = r_rd_pend;

    // Issue a read only if head+skid can absorb it together with the beat
    // already in flight, accounting for a pop this cycle.
    always_comb begin
        w_room = 1'b0;
        unique case (r_ob_cnt)
            2'd0:    w_room = 1'b1;
            2'd1:    w_room = !r_rd_pend || w_out_pop;
            2'd2:    w_room = !r_rd_pend && w_out_pop;
            default: w_room = 1'b0;
        endcase
    end

    assign w_rd_en = (r_rd_ptr != w_commit_ptr) && w_room;

    assign w_ob_cnt_nxt     = r_ob_cnt + {1'b0, w_push} - {1'b0, w_out_pop};
    assign w_load_head_q    = w_push && ((r_ob_cnt == 2'd0) || ((r_ob_cnt == 2'd1) && w_out_pop));
    assign w_load_head_skid = w_out_pop && (r_ob_cnt == 2'd2);
    assign w_load_skid      = w_push && (((r_ob_cnt == 2'd1) && !w_out_pop) ||
                                         ((r_ob_cnt == 2'd2) && w_out_pop));

    assign m_axis_tdata   = r_head[63:0];
    assign m_axis_tkeep   = r_head[71:64];
    assign m_axis_tlast   = r_head[72];
    assign m_axis_tuser   = 1'b0;
    assign m_axis_tvalid  = r_out_valid;

    assign frames_pending = r_frames_pending;
    assign drop_count     = r_drop_count;

    // RAM write port: accepted beats of a frame still eligible for commit.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_wr_word;
        end
    end

    // RAM read port, write-first on an address collision.
    always_ff @(posedge clock) begin
        if (w_rd_en) begin
            if (w_wr_en && (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0])) begin
                r_ram_q <= w_wr_word;
            end else begin
                r_ram_q <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    // Write FSM: store, commit on clean tlast, rewind on abort or overflow.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= c_ST_WRITE;
            r_in_en     <= 1'b0;
            r_wr_ptr    <= '0;
            r_wr_start  <= '0;
            r_wr_commit <= '0;
        end else begin
            r_in_en <= 1'b1;
            unique case (r_state)
                c_ST_WRITE: begin
                    if (w_overflow) begin
                        r_wr_ptr <= r_wr_start;
                        // The discarded beat may itself end the frame.
                        if (!(w_s_hs && s_axis_tlast)) begin
                            r_state <= c_ST_DROP;
                        end
                    end else if (w_wr_en) begin
                        if (s_axis_tlast && s_axis_tuser) begin
                            r_wr_ptr <= r_wr_start;
                        end else if (s_axis_tlast) begin
                            r_wr_ptr    <= w_wr_ptr_inc;
                            r_wr_start  <= w_wr_ptr_inc;
                            r_wr_commit <= w_wr_ptr_inc;
                        end else begin
                            r_wr_ptr <= w_wr_ptr_inc;
                        end
                    end
                end
                c_ST_DROP: begin
                    if (w_s_hs && s_axis_tlast) begin
                        r_state <= c_ST_WRITE;
                    end
                end
                default: r_state <= c_ST_WRITE;
            endcase
        end
    end

    // Saturating count of discarded frames.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_drop_count <= '0;
        end else if (w_drop_evt && (r_drop_count != c_DROP_MAX)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    // Committed-but-unsent frame count; simultaneous inc/dec cancel.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_frames_pending <= '0;
        end else begin
            unique case ({w_commit, w_out_last_hs})
                2'b10:   r_frames_pending <= r_frames_pending + c_PTR_ONE;
                2'b01:   r_frames_pending <= r_frames_pending - c_PTR_ONE;
                default: r_frames_pending <= r_frames_pending;
            endcase
        end
    end

    // Read pointer advance and one-cycle read-valid tracking.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr  <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_en;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Head/skid output stage; head holds steady while the MAC stalls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ob_cnt    <= 2'd0;
            r_out_valid <= 1'b0;
            r_head      <= '0;
            r_skid      <= '0;
        end else begin
            r_ob_cnt    <= w_ob_cnt_nxt;
            r_out_valid <= (w_ob_cnt_nxt != 2'd0);
            if (w_load_head_q) begin
                r_head <= r_ram_q;
            end else if (w_load_head_skid) begin
                r_head <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= r_ram_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_eth_tx_frame_fifo
//  Description : Self-checking bench for eth_tx_frame_fifo (ADDR_W = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_frame_fifo;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          resetn;
    logic [63:0]   s_axis_tdata;
    logic [7:0]    s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [AW:0]   frames_pending;
    logic [15:0]   drop_count;

    eth_tx_frame_fifo #(.ADDR_W(AW)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .frames_pending (frames_pending),
        .drop_count     (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          len;
        bit          abort;
        logic [7:0]  last_keep;
        logic [63:0] base;
        logic [63:0] step;
        bit          exp_pass;
        int          exp_drops;
    } vec_t;

    vec_t        vecs [9];
    logic [72:0] exp_q [$];

    int   tests, fails, cyc;
    int   smp_cyc, last_in_cyc, smp_fp;
    bit   smp_m_valid, smp_s_hs;
    bit   rand_rdy, bp_mode, track_fp;
    bit   mon_in_frame, prev_stall;
    logic [72:0] prev_word;
    int   gap_viol, stab_viol, full_viol, stall_cnt, max_fp;
    int   beats_in, beats_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Evaluate this cycle's handshakes (they complete at the next posedge),
    // then advance to the following negedge.
    task automatic tick();
        logic [72:0] w;
        #1;
        smp_cyc     = cyc;
        smp_m_valid = m_axis_tvalid;
        smp_fp      = int'(frames_pending);
        smp_s_hs    = s_axis_tvalid && s_axis_tready;
        if (resetn) begin
            if (s_axis_tvalid && !s_axis_tready) stall_cnt++;
            if (mon_in_frame && !m_axis_tvalid) gap_viol++;
            if (prev_stall && (!m_axis_tvalid ||
                {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== prev_word)) stab_viol++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            if (track_fp && int'(frames_pending) > max_fp) max_fp = int'(frames_pending);
            if (bp_mode && !s_axis_tready && (beats_in - beats_out) < DEPTH) full_viol++;
            if (smp_s_hs) beats_in++;
            if (m_axis_tvalid && m_axis_tready) begin
                beats_out++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %h, expected no output", m_axis_tdata);
                end else begin
                    w = exp_q.pop_front();
                    tests++;
                    if ({m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== {1'b0, w}) begin
                        fails++;
                        $display("FAIL out_beat: got last=%b keep=%h data=%h user=%b, expected last=%b keep=%h data=%h user=0",
                                 m_axis_tlast, m_axis_tkeep, m_axis_tdata, m_axis_tuser,
                                 w[72], w[71:64], w[63:0]);
                    end
                end
                mon_in_frame = !m_axis_tlast;
            end
        end
        @(negedge clock);
        cyc++;
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit last, input bit user);
        int n;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        tick();
        n = 0;
        while (!smp_s_hs && n < 2000) begin
            tick();
            n++;
        end
        if (!smp_s_hs) begin
            tests++;
            fails++;
            $display("FAIL in_timeout: got no accept in %0d cycles, expected accept", n);
        end
        if (last) last_in_cyc = smp_cyc;
    endtask

    task automatic send_frame(input int len, input bit abort, input logic [7:0] lkeep,
                              input logic [63:0] base, input logic [63:0] step, input bit push);
        for (int i = 0; i < len; i++) begin
            logic [63:0] d;
            logic [7:0]  k;
            bit          last;
            last = (i == len - 1);
            d    = base + step * 64'(i);
            k    = last ? lkeep : 8'hFF;
            if (push) exp_q.push_back({last, k, d});
            send_beat(d, k, last, last && abort);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        s_axis_tvalid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || frames_pending != '0) && n < 600) begin
            tick();
            n++;
        end
        tick();
        tick();
        check({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_pending"}, 64'(frames_pending), 64'd0);
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rand_rdy = 0; bp_mode = 0; track_fp = 0;
        mon_in_frame = 0; prev_stall = 0; prev_word = '0;
        gap_viol = 0; stab_viol = 0; full_viol = 0; stall_cnt = 0; max_fp = 0;
        beats_in = 0; beats_out = 0; last_in_cyc = 0;

        vecs[0] = '{3,  1'b0, 8'h0F, 64'h11,    64'h11, 1'b1, 0};
        vecs[1] = '{4,  1'b1, 8'hFF, 64'hA0,    64'h1,  1'b0, 1};
        vecs[2] = '{2,  1'b0, 8'hFF, 64'hB0,    64'h1,  1'b1, 1};
        vecs[3] = '{20, 1'b0, 8'hFF, 64'hC0,    64'h1,  1'b0, 2};
        vecs[4] = '{16, 1'b0, 8'h3F, 64'hD00,   64'h1,  1'b1, 2};
        vecs[5] = '{1,  1'b0, 8'h00, 64'hE0,    64'h1,  1'b1, 2};
        vecs[6] = '{17, 1'b0, 8'hFF, 64'hF00,   64'h1,  1'b0, 3};
        vecs[7] = '{1,  1'b1, 8'h01, 64'h77,    64'h1,  1'b0, 4};
        vecs[8] = '{5,  1'b0, 8'h01, 64'h1234_5678_9ABC_DEF0, 64'h0101_0101_0101_0101, 1'b1, 4};

        resetn        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        check("rst_m_tvalid",  64'(m_axis_tvalid),  64'd0);
        check("rst_s_tready",  64'(s_axis_tready),  64'd0);
        check("rst_pending",   64'(frames_pending), 64'd0);
        check("rst_drops",     64'(drop_count),     64'd0);
        check("rst_m_tdata",   m_axis_tdata,        64'd0);
        check("rst_m_tlast",   64'(m_axis_tlast),   64'd0);

        resetn        = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        tick();

        // Latency: first output beat two cycles after the input tlast
        send_frame(3, 1'b0, 8'h0F, 64'h11, 64'h11, 1'b1);
        tick();
        check("pending_after_commit", 64'(smp_fp), 64'd1);
        check("valid_at_n_plus_1", 64'(smp_m_valid), 64'd0);
        for (int n = 0; n < 8 && !smp_m_valid; n++) tick();
        check("latency_cycles", 64'(smp_cyc - last_in_cyc), 64'd2);
        drain("latency");

        // Table-driven frames, each starting from an empty buffer
        for (int v = 0; v < 9; v++) begin
            stall_cnt = 0;
            send_frame(vecs[v].len, vecs[v].abort, vecs[v].last_keep,
                       vecs[v].base, vecs[v].step, vecs[v].exp_pass);
            drain("vec");
            check("vec_drop_count", 64'(drop_count), 64'(vecs[v].exp_drops));
            check("vec_in_stall",   64'(stall_cnt),  64'd0);
        end

        // Backpressure: 10 x 7-beat frames, random MAC ready
        gap_viol = 0; stab_viol = 0; full_viol = 0;
        beats_in = 0; beats_out = 0;
        bp_mode = 1; rand_rdy = 1;
        for (int f = 0; f < 10; f++)
            send_frame(7, 1'b0, 8'h07, 64'(f) << 8, 64'h1, 1'b1);
        drain("bp");
        bp_mode = 0; rand_rdy = 0; m_axis_tready = 1'b1;
        check("bp_beats_out",   64'(beats_out), 64'd70);
        check("bp_tvalid_gap",  64'(gap_viol),  64'd0);
        check("bp_hold_stable", 64'(stab_viol), 64'd0);
        check("bp_ready_full",  64'(full_viol), 64'd0);

        // Wrap and simultaneity: continuous 5-beat frames, ready held high
        beats_out = 0; max_fp = 0; track_fp = 1; gap_viol = 0;
        for (int f = 0; f < 40; f++)
            send_frame(5, 1'b0, 8'hFF, (64'(f) << 16) | 64'h5000_0000, 64'h1, 1'b1);
        drain("wrap");
        track_fp = 0;
        check("wrap_beats_out",  64'(beats_out),      64'd200);
        check("wrap_pending_le3", 64'(max_fp <= 3),   64'd1);
        check("wrap_tvalid_gap", 64'(gap_viol),       64'd0);

        // Reset while the second output beat is presented
        send_frame(4, 1'b0, 8'hFF, 64'h500, 64'h1, 1'b1);
        for (int n = 0; n < 8 && !smp_m_valid; n++) tick();
        tick();
        check("mid_valid_before_rst", 64'(m_axis_tvalid), 64'd1);
        resetn = 1'b0;
        #1;
        check("mid_valid_in_rst", 64'(m_axis_tvalid), 64'd0);
        exp_q.delete();
        mon_in_frame = 0;
        prev_stall   = 0;
        @(negedge clock);
        @(negedge clock);
        check("mid_rst_pending", 64'(frames_pending), 64'd0);
        check("mid_rst_drops",   64'(drop_count),     64'd0);
        check("mid_rst_s_ready", 64'(s_axis_tready),  64'd0);
        resetn = 1'b1;
        tick();
        tick();
        check("post_rst_pending", 64'(smp_fp), 64'd0);
        send_frame(2, 1'b0, 8'h03, 64'h600, 64'h1, 1'b1);
        drain("post_rst");
        check("post_rst_drops", 64'(drop_count), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
